// File: rtl/comparator_pkg.sv
// ============================================================================
// Package : comparator_pkg
// Brief   : Shared cell result type and tree-depth helper for the comparator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package comparator_pkg;

    typedef struct packed {
        logic g;
        logic l;
    } cell_res_t;

    // Number of binary tree levels needed to reduce WIDTH bits to one node.
    function automatic int levels_f(input int width);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(width)) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmp2_cell.sv
// ============================================================================
// Module  : cmp2_cell
// Brief   : Combinational 2-bit magnitude compare producing greater/less flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp2_cell
    import comparator_pkg::*;
(
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic       g_o,
    output logic       l_o
);

    cell_res_t w_res;
    logic      w_hi_same;

    assign w_hi_same = ~(a_i[1] ^ b_i[1]);

    // Fed with a={g_hi,g_lo}, b={l_hi,l_lo} the same logic merges two child results.
    always_comb begin
        w_res   = '0;
        w_res.g = (a_i[1] & ~b_i[1]) | (w_hi_same & a_i[0] & ~b_i[0]);
        w_res.l = (~a_i[1] & b_i[1]) | (w_hi_same & ~a_i[0] & b_i[0]);
    end

    assign g_o = w_res.g;
    assign l_o = w_res.l;

endmodule

`default_nettype wire

// File: rtl/comparator_tree_pipe.sv
// ============================================================================
// Module  : comparator_tree_pipe
// Brief   : Pipelined log2(WIDTH)-level signed/unsigned magnitude comparator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_tree_pipe
    import comparator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_gt,
    output logic             out_lt,
    output logic             out_eq,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = levels_f(WIDTH);
    // All levels packed into one vector: level n starts at WIDTH - (WIDTH >> n).
    localparam int NODES  = WIDTH - 1;

    logic             w_en;
    logic [WIDTH-1:0] w_x_t;
    logic [WIDTH-1:0] w_y_t;

    logic [NODES-1:0]  g_d;
    logic [NODES-1:0]  l_d;
    logic [NODES-1:0]  g_q;
    logic [NODES-1:0]  l_q;
    logic [LEVELS-1:0] valid_d;
    logic [LEVELS-1:0] valid_q;
    logic [TAG_W-1:0]  tag_d [LEVELS];
    logic [TAG_W-1:0]  tag_q [LEVELS];

    assign w_en     = out_ready | ~out_valid;
    assign in_ready = w_en;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_x_t = {in_x[WIDTH-1] ^ in_signed, in_x[WIDTH-2:0]};
    assign w_y_t = {in_y[WIDTH-1] ^ in_signed, in_y[WIDTH-2:0]};

    for (genvar n = 0; n < LEVELS; n++) begin : g_lvl
        localparam int CELLS = WIDTH >> (n + 1);
        localparam int OFS   = WIDTH - (WIDTH >> n);

        for (genvar k = 0; k < CELLS; k++) begin : g_node
            if (n == 0) begin : g_leaf
                cmp2_cell u_cell (
                    .a_i (w_x_t[2*k+1:2*k]),
                    .b_i (w_y_t[2*k+1:2*k]),
                    .g_o (g_d[OFS+k]),
                    .l_o (l_d[OFS+k])
                );
            end else begin : g_join
                localparam int SRC = WIDTH - (WIDTH >> (n - 1));

                cmp2_cell u_cell (
                    .a_i ({g_q[SRC+2*k+1], g_q[SRC+2*k]}),
                    .b_i ({l_q[SRC+2*k+1], l_q[SRC+2*k]}),
                    .g_o (g_d[OFS+k]),
                    .l_o (l_d[OFS+k])
                );
            end
        end
    end

    always_comb begin
        valid_d  = {valid_q[LEVELS-2:0], in_valid};
        tag_d[0] = in_tag;
        for (int s = 1; s < LEVELS; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            g_q     <= '0;
            l_q     <= '0;
            for (int s = 0; s < LEVELS; s++) begin
                tag_q[s] <= '0;
            end
        end else if (w_en) begin
            valid_q <= valid_d;
            g_q     <= g_d;
            l_q     <= l_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q[LEVELS-1];
    assign out_gt    = g_q[NODES-1];
    assign out_lt    = l_q[NODES-1];
    assign out_eq    = ~out_gt & ~out_lt;
    assign out_tag   = tag_q[LEVELS-1];

endmodule

`default_nettype wire

// File: tb/tb_comparator_tree_pipe.sv
// ============================================================================
// Module  : tb_comparator_tree_pipe
// Brief   : Self-checking bench for comparator_tree_pipe against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comparator_tree_pipe;

    localparam int WIDTH  = 16;
    localparam int TAG_W  = 4;
    localparam int LEVELS = 4;

    typedef logic [TAG_W+2:0] res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_signed;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_gt;
    logic             out_lt;
    logic             out_eq;
    logic [TAG_W-1:0] out_tag;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    comparator_tree_pipe #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gt    (out_gt),
        .out_lt    (out_lt),
        .out_eq    (out_eq),
        .out_tag   (out_tag)
    );

    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s, input logic [TAG_W-1:0] t);
        logic gt;
        logic lt;
        if (s) begin
            gt = $signed(x) > $signed(y);
            lt = $signed(x) < $signed(y);
        end else begin
            gt = x > y;
            lt = x < y;
        end
        return {gt, lt, ~gt & ~lt, t};
    endfunction

    function automatic res_t observed();
        return {out_gt, out_lt, out_eq, out_tag};
    endfunction

    task automatic drive_rand();
        in_x      = WIDTH'($urandom);
        in_y      = WIDTH'($urandom);
        if ($urandom_range(0, 5) == 0) in_y = in_x;
        in_signed = 1'($urandom);
        in_tag    = TAG_W'($urandom);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_rand();
        repeat (3) next_cycle();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (observed() !== {1'b0, 1'b0, 1'b1, {TAG_W{1'b0}}}) begin
            n_err++; $display("FAIL reset_outputs: got %h want %h", observed(), {3'b001, {TAG_W{1'b0}}});
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < LEVELS + 2; c++) begin
            next_cycle();
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_accept: cycle %0d got %b want 0", c, out_valid); end
        end
        next_cycle();
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] tx [4];
        logic [WIDTH-1:0] ty [4];
        logic             ts [4];
        logic [TAG_W-1:0] tt [4];
        res_t             te [4];
        tx = '{16'h8000, 16'h8000, 16'hA5A5, 16'hA5A5};
        ty = '{16'h7FFF, 16'h7FFF, 16'hA5A5, 16'hA5A5};
        ts = '{1'b0, 1'b1, 1'b0, 1'b1};
        tt = '{4'd3, 4'd5, 4'd9, 4'd10};
        te = '{{3'b100, 4'd3}, {3'b010, 4'd5}, {3'b001, 4'd9}, {3'b001, 4'd10}};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int lat;
            lat       = -1;
            in_x      = tx[i];
            in_y      = ty[i];
            in_signed = ts[i];
            in_tag    = tt[i];
            in_valid  = 1'b1;
            next_cycle();
            in_valid  = 1'b0;
            for (int c = 1; c <= LEVELS + 3 && lat < 0; c++) begin
                @(negedge clk);
                if (out_valid === 1'b1) begin
                    lat = c;
                    n_cmp++; if (observed() !== te[i]) begin
                        n_err++; $display("FAIL directed_%0d_result: got %h want %h", i, observed(), te[i]);
                    end
                end
                next_cycle();
            end
            n_cmp++; if (lat != LEVELS) begin n_err++; $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, LEVELS); end
        end
    endtask

    task automatic test_back_to_back();
        int   first;
        int   got;
        res_t e;
        first = -1;
        got   = 0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8 + LEVELS + 4; cyc++) begin
            if (cyc < 8) begin drive_rand(); in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL stream_extra: got %h want none", observed());
                end else begin
                    e = exp_q.pop_front();
                    if (observed() !== e) begin n_err++; $display("FAIL stream_result: got %h want %h", observed(), e); end
                end
                n_cmp++; if (cyc != first + got) begin n_err++; $display("FAIL stream_gap: got cycle %0d want %0d", cyc, first + got); end
                got++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_x, in_y, in_signed, in_tag));
            next_cycle();
        end
        n_cmp++; if (got != 8) begin n_err++; $display("FAIL stream_count: got %0d want 8", got); end
        n_cmp++; if (first != LEVELS) begin n_err++; $display("FAIL stream_latency: got %0d want %0d", first, LEVELS); end
    endtask

    task automatic test_backpressure();
        int   got;
        int   pushed;
        res_t e;
        got    = 0;
        pushed = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 32; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            if (cyc < 14) begin drive_rand(); in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(negedge clk);
            if (!out_ready) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", cyc, in_ready); end
                n_cmp++; if (out_valid !== 1'b1 || exp_q.size() == 0 || observed() !== exp_q[0]) begin
                    n_err++; $display("FAIL bp_hold: cycle %0d got v=%b %h", cyc, out_valid, observed());
                end
            end else if (out_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL bp_extra: got %h want none", observed());
                end else begin
                    e = exp_q.pop_front();
                    if (observed() !== e) begin n_err++; $display("FAIL bp_result: got %h want %h", observed(), e); end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_x, in_y, in_signed, in_tag));
                pushed++;
            end
            next_cycle();
        end
        out_ready = 1'b1;
        n_cmp++; if (pushed != 9) begin n_err++; $display("FAIL bp_accepted: got %0d want 9", pushed); end
        n_cmp++; if (got != 9 || exp_q.size() != 0) begin
            n_err++; $display("FAIL bp_delivered: got %0d left %0d want 9 left 0", got, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            in_valid = 1'b1;
            next_cycle();
        end
        rst = 1'b1;
        drive_rand();
        next_cycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_first: got %b want 0", out_valid); end
        for (int c = 0; c < LEVELS + 4; c++) begin
            next_cycle();
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_flush: cycle %0d got %b want 0", c, out_valid); end
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic prev_stall;
        res_t prev_obs;
        res_t e;
        prev_stall = 1'b0;
        prev_obs   = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 300 + LEVELS + 6; cyc++) begin
            if (cyc < 300) begin
                drive_rand();
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            n_cmp++; if (in_ready !== (out_ready | ~out_valid)) begin
                n_err++; $display("FAIL rand_in_ready: cycle %0d got %b", cyc, in_ready);
            end
            if (prev_stall) begin
                n_cmp++; if (out_valid !== 1'b1 || observed() !== prev_obs) begin
                    n_err++; $display("FAIL rand_stable: cycle %0d got %h want %h", cyc, observed(), prev_obs);
                end
            end
            if (out_valid === 1'b1) begin
                n_cmp++; if ((32'(out_gt) + 32'(out_lt) + 32'(out_eq)) != 1) begin
                    n_err++; $display("FAIL rand_onehot: got %b%b%b", out_gt, out_lt, out_eq);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rand_extra: got %h want none", observed());
                end else begin
                    e = exp_q.pop_front();
                    if (observed() !== e) begin n_err++; $display("FAIL rand_result: got %h want %h", observed(), e); end
                end
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_obs   = observed();
            if (in_valid && in_ready) exp_q.push_back(model(in_x, in_y, in_signed, in_tag));
            next_cycle();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_drain: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_x      = '0;
        in_y      = '0;
        in_signed = 1'b0;
        in_tag    = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
